// File: rtl/keybuf_pkg.sv
// Shared definitions for the keypad key buffer: write-FSM state encodings
// and the ceiling-log2 helper used to size the pointers.
package keybuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Smallest r with 2**r >= n; used for pointer width derivation.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/keybuf_mem.sv
// Key buffer storage: DEPTH x DATA_W register array with one synchronous
// write port and a registered read port (read data cleared on reset so the
// consumer sees a known zero code before the first pop).
module keybuf_mem #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage array: one entry written per write strobe, no reset on contents.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read port: holds its last value when no pop occurs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/keybuf_ctrl.sv
// Keypad key buffer controller: one write per key press into a DEPTH-entry
// circular buffer, popped by the consumer under a read/valid handshake.
// Optional feature macro: KEYBUF_OVERFLOW_EN adds a sticky overflow output
// flagging presses dropped while the buffer was full.
module keybuf_ctrl
  import keybuf_pkg::*;
#(
  parameter  int DATA_W = 4,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = clog2_f(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              v,
  input  logic [DATA_W-1:0] code,
  input  logic              read,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              wr_enable,
  output logic              rd_enable,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
`ifdef KEYBUF_OVERFLOW_EN
  ,
  output logic              overflow
`endif
);

  localparam logic [ADDR_W:0]   LP_CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LP_CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_PTR_ONE  = ADDR_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_code;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     w_count_nxt;
  logic                r_full;
  logic                r_empty;
  logic                r_valid;
  logic                w_wr_en;
  logic                w_rd_en;
  logic                w_capture;

  // Write FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Write FSM next state: one write per press, wait for release before re-arming.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (v && !r_full)     w_state_nxt = ST_WRITE;
        else if (v && r_full) w_state_nxt = ST_HOLD;
      end
      ST_WRITE: w_state_nxt = ST_HOLD;
      ST_HOLD:  if (!v) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Write FSM outputs: capture in IDLE, write strobe for exactly the WRITE cycle.
  always_comb begin
    w_capture = (r_state == ST_IDLE) && v && !r_full;
    w_wr_en   = (r_state == ST_WRITE);
  end

  // Captured key code, held until the WRITE cycle commits it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         r_code <= '0;
    else if (w_capture) r_code <= code;
  end

  // Pop is allowed only from a registered non-empty buffer (no fall-through).
  assign w_rd_en = read && !r_empty;

  // Occupancy after this edge; a write and a pop together cancel out.
  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_wr_en, w_rd_en})
      2'b10:   w_count_nxt = r_count + LP_CNT_ONE;
      2'b01:   w_count_nxt = r_count - LP_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, count, flags and valid pulse all move on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == LP_CNT_FULL);
      r_empty <= (w_count_nxt == '0);
      r_valid <= w_rd_en;
    end
  end

`ifdef KEYBUF_OVERFLOW_EN
  logic r_overflow;
  logic w_drop;

  assign w_drop = (r_state == ST_IDLE) && v && r_full;

  // Sticky dropped-press flag; cleared when the consumer reads an empty buffer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                r_overflow <= 1'b0;
    else if (w_drop)           r_overflow <= 1'b1;
    else if (read && r_empty)  r_overflow <= 1'b0;
  end

  assign overflow = r_overflow;
`endif

  keybuf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (r_code),
    .i_re    (w_rd_en),
    .i_raddr (r_rd_ptr),
    .o_rdata (dout)
  );

  assign valid     = r_valid;
  assign wr_enable = w_wr_en;
  assign rd_enable = w_rd_en;
  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;

endmodule

// File: tb/tb_keybuf_ctrl.sv
// Directed testbench for keybuf_ctrl (DATA_W=4, DEPTH=8).
module tb_keybuf_ctrl;

  logic       clock;
  logic       reset;
  logic       v;
  logic [3:0] code;
  logic       read;
  logic [3:0] dout;
  logic       valid;
  logic       wr_enable;
  logic       rd_enable;
  logic       full;
  logic       empty;
  logic [3:0] count;
`ifdef KEYBUF_OVERFLOW_EN
  logic       overflow;
`endif

  int n_pass;
  int n_tot;

  keybuf_ctrl #(.DATA_W(4), .DEPTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .v         (v),
    .code      (code),
    .read      (read),
    .dout      (dout),
    .valid     (valid),
    .wr_enable (wr_enable),
    .rd_enable (rd_enable),
    .full      (full),
    .empty     (empty),
    .count     (count)
`ifdef KEYBUF_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One key press held for h sampled cycles; returns number of wr_enable pulses.
  task automatic press(input logic [3:0] c, input int h, output int nwr);
    nwr  = 0;
    code = c;
    v    = 1'b1;
    step();
    for (int i = 0; i < h; i++) begin
      if (wr_enable) nwr++;
      step();
    end
    v = 1'b0;
    step();
    step();
  endtask

  // Pop one entry and check the returned code.
  task automatic pop_expect(input string tag, input logic [3:0] exp);
    read = 1'b1;
    #1;
    chk({tag, "_rden"}, rd_enable, 1);
    step();
    read = 1'b0;
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_dout"}, dout, exp);
  endtask

  initial begin
    int nwr;
    n_pass = 0;
    n_tot  = 0;
    reset  = 1'b0;
    v      = 1'b1;
    code   = 4'hF;
    read   = 1'b1;

    // 1: reset with v and read asserted
    repeat (3) step();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_valid", valid, 0);
    chk("rst_wren",  wr_enable, 0);
    chk("rst_rden",  rd_enable, 0);
    chk("rst_dout",  dout, 0);
`ifdef KEYBUF_OVERFLOW_EN
    chk("rst_ovf",   overflow, 0);
`endif
    v    = 1'b0;
    read = 1'b0;
    step();
    reset = 1'b1;
    step();

    // 2: single press held 4 cycles, then pop
    press(4'h5, 4, nwr);
    chk("single_wrpulses", nwr, 1);
    chk("single_count", count, 1);
    chk("single_empty", empty, 0);
    read = 1'b1;
    #1;
    chk("single_rden", rd_enable, 1);
    step();
    chk("single_valid", valid, 1);
    chk("single_dout", dout, 5);
    chk("single_empty2", empty, 1);
    chk("single_rden_off", rd_enable, 0);
    step();
    read = 1'b0;
    chk("single_valid_pulse", valid, 0);

    // 3: fill with 0..7, drop ninth press, drain in order
    for (int i = 0; i < 8; i++) begin
      press(4'(i), 1, nwr);
      chk($sformatf("fill_wr%0d", i), nwr, 1);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    press(4'h9, 2, nwr);
    chk("ovf_wrpulses", nwr, 0);
    chk("ovf_count", count, 8);
`ifdef KEYBUF_OVERFLOW_EN
    chk("ovf_flag", overflow, 1);
`endif
    for (int i = 0; i < 8; i++) pop_expect($sformatf("drain%0d", i), 4'(i));
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    read = 1'b1;
    #1;
    chk("empty_rden", rd_enable, 0);
    step();
    read = 1'b0;
    chk("empty_valid", valid, 0);
    chk("empty_dout_hold", dout, 7);
`ifdef KEYBUF_OVERFLOW_EN
    chk("ovf_cleared", overflow, 0);
`endif

    // 4: pointer wrap
    for (int i = 1; i <= 6; i++) press(4'(i), 1, nwr);
    for (int i = 1; i <= 6; i++) pop_expect($sformatf("wrapA%0d", i), 4'(i));
    for (int i = 10; i <= 15; i++) press(4'(i), 1, nwr);
    chk("wrap_count", count, 6);
    for (int i = 10; i <= 15; i++) pop_expect($sformatf("wrapB%0d", i), 4'(i));
    chk("wrap_empty", empty, 1);

    // 5a: simultaneous write and pop at count 3
    for (int i = 1; i <= 3; i++) press(4'(i), 1, nwr);
    chk("sim_count_pre", count, 3);
    code = 4'h4;
    v    = 1'b1;
    step();
    read = 1'b1;
    #1;
    chk("sim_wren", wr_enable, 1);
    chk("sim_rden", rd_enable, 1);
    step();
    read = 1'b0;
    chk("sim_count", count, 3);
    chk("sim_valid", valid, 1);
    chk("sim_dout", dout, 1);
    v = 1'b0;
    step();
    step();
    pop_expect("sim_d2", 4'h2);
    pop_expect("sim_d3", 4'h3);
    pop_expect("sim_d4", 4'h4);
    chk("sim_empty", empty, 1);

    // 5b: write into empty buffer with read held: pop only the cycle after
    code = 4'h8;
    v    = 1'b1;
    read = 1'b1;
    step();
    chk("nft_wren", wr_enable, 1);
    chk("nft_rden0", rd_enable, 0);
    chk("nft_valid0", valid, 0);
    step();
    chk("nft_count", count, 1);
    chk("nft_valid1", valid, 0);
    chk("nft_rden1", rd_enable, 1);
    step();
    chk("nft_valid2", valid, 1);
    chk("nft_dout", dout, 8);
    chk("nft_empty", empty, 1);
    read = 1'b0;
    v    = 1'b0;
    step();
    step();

    // 6: reset mid-operation with FSM in HOLD
    for (int i = 1; i <= 4; i++) press(4'(i), 1, nwr);
    code = 4'h5;
    v    = 1'b1;
    step();
    step();
    chk("mid_count_pre", count, 5);
    reset = 1'b0;
    #1;
    chk("mid_count", count, 0);
    chk("mid_empty", empty, 1);
    chk("mid_valid", valid, 0);
    chk("mid_wren", wr_enable, 0);
`ifdef KEYBUF_OVERFLOW_EN
    chk("mid_ovf", overflow, 0);
`endif
    v = 1'b0;
    step();
    reset = 1'b1;
    step();
    press(4'hC, 1, nwr);
    chk("post_wrpulses", nwr, 1);
    chk("post_count", count, 1);
    pop_expect("post_pop", 4'hC);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
